// File: rtl/regfile_arbiter.sv
// Round-robin arbiter serializing two requesters onto one register file.
// A 4-cycle issue/wait/done sequence per access; clears take priority in IDLE.
module regfile_arbiter #(
  parameter int WORD_SIZE     = 16,
  parameter int REG_ADDR_SIZE = 3,
  parameter int REG_NUM       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_a,
  input  logic                     we_a,
  input  logic [REG_ADDR_SIZE-1:0] addr1_a,
  input  logic [REG_ADDR_SIZE-1:0] addr2_a,
  input  logic [WORD_SIZE-1:0]     wdata_a,
  output logic                     ack_a,
  output logic [WORD_SIZE-1:0]     rdata1_a,
  output logic [WORD_SIZE-1:0]     rdata2_a,
  input  logic                     req_b,
  input  logic                     we_b,
  input  logic [REG_ADDR_SIZE-1:0] addr1_b,
  input  logic [REG_ADDR_SIZE-1:0] addr2_b,
  input  logic [WORD_SIZE-1:0]     wdata_b,
  output logic                     ack_b,
  output logic [WORD_SIZE-1:0]     rdata1_b,
  output logic [WORD_SIZE-1:0]     rdata2_b,
  input  logic                     clear_req,
  output logic                     clear_done,
  output logic                     busy,
  output logic [REG_ADDR_SIZE-1:0] rf_num1,
  output logic [REG_ADDR_SIZE-1:0] rf_num2,
  output logic [WORD_SIZE-1:0]     rf_set_val,
  output logic                     rf_get_enable,
  output logic                     rf_set_enable,
  output logic                     rf_reset_enable,
  input  logic [WORD_SIZE-1:0]     rf_out1,
  input  logic [WORD_SIZE-1:0]     rf_out2
);

  localparam int unsigned RegSpan = 1 << REG_ADDR_SIZE;

  if (REG_NUM > RegSpan) begin : g_reg_num_check
    $error("REG_NUM does not fit in REG_ADDR_SIZE");
  end

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DONE, CLEAR
  } state_t;

  state_t state_q, state_d;

  logic last_b_q, last_b_d;
  logic pend_q, pend_d;
  logic win_b_q, win_b_d;
  logic we_q, we_d;
  logic grant_b;

  logic [REG_ADDR_SIZE-1:0] num1_q, num1_d;
  logic [REG_ADDR_SIZE-1:0] num2_q, num2_d;
  logic [WORD_SIZE-1:0]     set_val_q, set_val_d;
  logic get_en_q, get_en_d;
  logic set_en_q, set_en_d;
  logic rst_en_q, rst_en_d;
  logic ack_a_q, ack_a_d;
  logic ack_b_q, ack_b_d;
  logic clr_done_q, clr_done_d;
  logic busy_q, busy_d;

  logic [WORD_SIZE-1:0] rd1_a_q, rd1_a_d;
  logic [WORD_SIZE-1:0] rd2_a_q, rd2_a_d;
  logic [WORD_SIZE-1:0] rd1_b_q, rd1_b_d;
  logic [WORD_SIZE-1:0] rd2_b_q, rd2_b_d;

  // b wins when alone, or when both ask and a was granted last
  assign grant_b = req_b & (~req_a | ~last_b_q);

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    pend_d     = pend_q | clear_req;
    win_b_d    = win_b_q;
    we_d       = we_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    set_val_d  = set_val_q;
    get_en_d   = 1'b0;
    set_en_d   = 1'b0;
    rst_en_d   = 1'b0;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    clr_done_d = 1'b0;
    rd1_a_d    = rd1_a_q;
    rd2_a_d    = rd2_a_q;
    rd1_b_d    = rd1_b_q;
    rd2_b_d    = rd2_b_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q || clear_req) begin
          state_d  = CLEAR;
          rst_en_d = 1'b1;
        end else if (req_a || req_b) begin
          state_d   = ISSUE;
          win_b_d   = grant_b;
          last_b_d  = grant_b;
          we_d      = grant_b ? we_b : we_a;
          num1_d    = grant_b ? addr1_b : addr1_a;
          num2_d    = grant_b ? addr2_b : addr2_a;
          set_val_d = grant_b ? wdata_b : wdata_a;
          set_en_d  = we_d;
          get_en_d  = ~we_d;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = DONE;
        if (!we_q) begin
          if (win_b_q) begin
            rd1_b_d = rf_out1;
            rd2_b_d = rf_out2;
          end else begin
            rd1_a_d = rf_out1;
            rd2_a_d = rf_out2;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ack_a_d = ~win_b_q;
        ack_b_d = win_b_q;
      end
      CLEAR: begin
        state_d    = IDLE;
        clr_done_d = 1'b1;
        pend_d     = clear_req;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; last grant resets to b so a wins first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      pend_q     <= 1'b0;
      win_b_q    <= 1'b0;
      we_q       <= 1'b0;
      num1_q     <= '0;
      num2_q     <= '0;
      set_val_q  <= '0;
      get_en_q   <= 1'b0;
      set_en_q   <= 1'b0;
      rst_en_q   <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
      rd1_a_q    <= '0;
      rd2_a_q    <= '0;
      rd1_b_q    <= '0;
      rd2_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      pend_q     <= pend_d;
      win_b_q    <= win_b_d;
      we_q       <= we_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      set_val_q  <= set_val_d;
      get_en_q   <= get_en_d;
      set_en_q   <= set_en_d;
      rst_en_q   <= rst_en_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      rd1_a_q    <= rd1_a_d;
      rd2_a_q    <= rd2_a_d;
      rd1_b_q    <= rd1_b_d;
      rd2_b_q    <= rd2_b_d;
    end
  end

  assign ack_a           = ack_a_q;
  assign ack_b           = ack_b_q;
  assign rdata1_a        = rd1_a_q;
  assign rdata2_a        = rd2_a_q;
  assign rdata1_b        = rd1_b_q;
  assign rdata2_b        = rd2_b_q;
  assign clear_done      = clr_done_q;
  assign busy            = busy_q;
  assign rf_num1         = num1_q;
  assign rf_num2         = num2_q;
  assign rf_set_val      = set_val_q;
  assign rf_get_enable   = get_en_q;
  assign rf_set_enable   = set_en_q;
  assign rf_reset_enable = rst_en_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter with a behavioural register file
// and a transaction-level reference model.
module tb_regfile_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [2:0] addr1_a = 0, addr2_a = 0, addr1_b = 0, addr2_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;
  logic ack_a, ack_b;
  logic [15:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
  logic clear_req = 0;
  logic clear_done, busy;
  logic [2:0] rf_num1, rf_num2;
  logic [15:0] rf_set_val;
  logic rf_get_enable, rf_set_enable, rf_reset_enable;
  logic [15:0] rf_out1 = '0, rf_out2 = '0;

  logic [15:0] rf_mem [8] = '{default: 16'h0};

  int passed = 0;
  int total = 0;

  regfile_arbiter dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr1_a(addr1_a),
    .addr2_a(addr2_a), .wdata_a(wdata_a), .ack_a(ack_a),
    .rdata1_a(rdata1_a), .rdata2_a(rdata2_a),
    .req_b(req_b), .we_b(we_b), .addr1_b(addr1_b),
    .addr2_b(addr2_b), .wdata_b(wdata_b), .ack_b(ack_b),
    .rdata1_b(rdata1_b), .rdata2_b(rdata2_b),
    .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
    .rf_num1(rf_num1), .rf_num2(rf_num2), .rf_set_val(rf_set_val),
    .rf_get_enable(rf_get_enable), .rf_set_enable(rf_set_enable),
    .rf_reset_enable(rf_reset_enable),
    .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  always #5 clock = ~clock;

  // behavioural register file attached to the arbiter
  always @(posedge clock) begin
    if (rf_reset_enable) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
    end else if (rf_set_enable) begin
      rf_mem[rf_num1] <= rf_set_val;
    end
    if (rf_get_enable) begin
      rf_out1 <= rf_mem[rf_num1];
      rf_out2 <= rf_mem[rf_num2];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble();
    we_a = 1'($urandom); we_b = 1'($urandom);
    addr1_a = 3'($urandom); addr2_a = 3'($urandom);
    addr1_b = 3'($urandom); addr2_b = 3'($urandom);
    wdata_a = 16'($urandom); wdata_b = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++;
    if ({ack_a, ack_b, clear_done, busy} !== 4'b0) begin
      $display("FAIL reset_flags got %b want 0000",
               {ack_a, ack_b, clear_done, busy});
    end else passed++;
    total++;
    if ({rf_get_enable, rf_set_enable, rf_reset_enable} !== 3'b0) begin
      $display("FAIL reset_en got %b want 000",
               {rf_get_enable, rf_set_enable, rf_reset_enable});
    end else passed++;
    total++;
    if ({rf_num1, rf_num2, rf_set_val} !== 22'h0) begin
      $display("FAIL reset_rfbus got %h want 0",
               {rf_num1, rf_num2, rf_set_val});
    end else passed++;
    total++;
    if ({rdata1_a, rdata2_a, rdata1_b, rdata2_b} !== 64'h0) begin
      $display("FAIL reset_rdata got %h want 0",
               {rdata1_a, rdata2_a, rdata1_b, rdata2_b});
    end else passed++;
  endtask

  task automatic test_write();
    req_a = 1; we_a = 1; addr1_a = 3; addr2_a = 6; wdata_a = 16'h1234;
    step();
    scramble();
    total++;
    if ({rf_set_enable, rf_get_enable, rf_reset_enable} !== 3'b100) begin
      $display("FAIL write_issue_en got %b want 100",
               {rf_set_enable, rf_get_enable, rf_reset_enable});
    end else passed++;
    total++;
    if (rf_num1 !== 3'd3 || rf_set_val !== 16'h1234) begin
      $display("FAIL write_issue_bus got %0d/%h want 3/1234",
               rf_num1, rf_set_val);
    end else passed++;
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL write_busy got %b want 1", busy);
    end else passed++;
    step();
    total++;
    if ({rf_set_enable, rf_get_enable} !== 2'b00) begin
      $display("FAIL write_wait_en got %b want 00",
               {rf_set_enable, rf_get_enable});
    end else passed++;
    step();
    total++;
    if ({ack_a, ack_b} !== 2'b00) begin
      $display("FAIL write_done_early got %b want 00", {ack_a, ack_b});
    end else passed++;
    step();
    total++;
    if ({ack_a, ack_b, busy} !== 3'b100) begin
      $display("FAIL write_ack got %b want 100", {ack_a, ack_b, busy});
    end else passed++;
    req_a = 0;
    step();
    total++;
    if ({ack_a, ack_b, busy} !== 3'b000) begin
      $display("FAIL write_ack_pulse got %b want 000", {ack_a, ack_b, busy});
    end else passed++;
  endtask

  task automatic test_read();
    req_b = 1; we_b = 0; addr1_b = 3; addr2_b = 5;
    step();
    total++;
    if ({rf_set_enable, rf_get_enable} !== 2'b01 ||
        rf_num1 !== 3'd3 || rf_num2 !== 3'd5) begin
      $display("FAIL read_issue got en=%b n1=%0d n2=%0d want 01/3/5",
               {rf_set_enable, rf_get_enable}, rf_num1, rf_num2);
    end else passed++;
    scramble();
    step();
    step();
    step();
    total++;
    if ({ack_a, ack_b} !== 2'b01) begin
      $display("FAIL read_ack got %b want 01", {ack_a, ack_b});
    end else passed++;
    total++;
    if (rdata1_b !== 16'h1234 || rdata2_b !== 16'h0) begin
      $display("FAIL read_data got %h/%h want 1234/0000",
               rdata1_b, rdata2_b);
    end else passed++;
    total++;
    if ({rdata1_a, rdata2_a} !== 32'h0) begin
      $display("FAIL read_loser got %h want 0", {rdata1_a, rdata2_a});
    end else passed++;
    req_b = 0;
    step();
  endtask

  task automatic test_contention();
    reset = 1;
    step();
    reset = 0;
    req_a = 1; req_b = 1; we_a = 0; we_b = 0;
    for (int c = 1; c <= 16; c++) begin
      logic ea, eb, eq;
      step();
      ea = (c % 8 == 4);
      eb = (c % 8 == 0);
      eq = (c % 4 != 0);
      total++;
      if ({ack_a, ack_b, busy} !== {ea, eb, eq}) begin
        $display("FAIL contend_c%0d got %b want %b",
                 c, {ack_a, ack_b, busy}, {ea, eb, eq});
      end else passed++;
    end
    req_a = 0; req_b = 0;
  endtask

  task automatic test_async_reset();
    reset = 1;
    step();
    reset = 0;
    req_a = 1; we_a = 0; addr1_a = 1; addr2_a = 2;
    step();
    req_a = 0;
    step();
    #2 reset = 1;
    #1;
    total++;
    if ({ack_a, ack_b, busy, rf_get_enable, rf_num1, rf_num2} !== 10'h0) begin
      $display("FAIL areset_now got %h want 0",
               {ack_a, ack_b, busy, rf_get_enable, rf_num1, rf_num2});
    end else passed++;
    step();
    step();
    total++;
    if ({ack_a, ack_b, rdata1_a, rdata2_a} !== 34'h0) begin
      $display("FAIL areset_noack got %h want 0",
               {ack_a, ack_b, rdata1_a, rdata2_a});
    end else passed++;
    reset = 0;
    req_a = 1; req_b = 1; we_a = 0; we_b = 0;
    addr1_a = 4; addr1_b = 7;
    step();
    total++;
    if (rf_num1 !== 3'd4 || rf_get_enable !== 1'b1) begin
      $display("FAIL areset_first got n1=%0d get=%b want 4/1",
               rf_num1, rf_get_enable);
    end else passed++;
    step();
    step();
    step();
    total++;
    if ({ack_a, ack_b} !== 2'b10) begin
      $display("FAIL areset_ack got %b want 10", {ack_a, ack_b});
    end else passed++;
    req_a = 0; req_b = 0;
    step();
    step();
    step();
    step();
    req_b = 0;
  endtask

  task automatic test_clear();
    req_a = 1; we_a = 1; addr1_a = 2; wdata_a = 16'hbeef;
    step();
    clear_req = 1;
    req_b = 1; we_b = 0; addr1_b = 2; addr2_b = 2;
    step();
    clear_req = 0;
    step();
    step();
    total++;
    if ({ack_a, ack_b} !== 2'b10) begin
      $display("FAIL clear_ack_a got %b want 10", {ack_a, ack_b});
    end else passed++;
    req_a = 0;
    step();
    total++;
    if ({rf_reset_enable, rf_set_enable, rf_get_enable, busy} !== 4'b1001) begin
      $display("FAIL clear1_state got %b want 1001",
               {rf_reset_enable, rf_set_enable, rf_get_enable, busy});
    end else passed++;
    clear_req = 1;
    step();
    clear_req = 0;
    total++;
    if ({clear_done, rf_reset_enable} !== 2'b10) begin
      $display("FAIL clear1_done got %b want 10", {clear_done, rf_reset_enable});
    end else passed++;
    step();
    total++;
    if ({rf_reset_enable, rf_get_enable, clear_done} !== 3'b100) begin
      $display("FAIL clear2_state got %b want 100",
               {rf_reset_enable, rf_get_enable, clear_done});
    end else passed++;
    step();
    total++;
    if (clear_done !== 1'b1) begin
      $display("FAIL clear2_done got %b want 1", clear_done);
    end else passed++;
    step();
    total++;
    if ({rf_get_enable, clear_done} !== 2'b10 || rf_num1 !== 3'd2) begin
      $display("FAIL clear_b_issue got %b n1=%0d want 10/2",
               {rf_get_enable, clear_done}, rf_num1);
    end else passed++;
    step();
    step();
    step();
    total++;
    if ({ack_b, rdata1_b} !== {1'b1, 16'h0}) begin
      $display("FAIL clear_b_read got %b/%h want 1/0000", ack_b, rdata1_b);
    end else passed++;
    req_b = 0;
  endtask

  task automatic test_random();
    logic [15:0] m_mem [8];
    logic [15:0] m_rd1 [2];
    logic [15:0] m_rd2 [2];
    int m_last;
    bit m_clear;
    m_last = 1;
    m_clear = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      m_rd1[i] = '0;
      m_rd2[i] = '0;
    end
    for (int it = 0; it < 48; it++) begin
      bit ra, rb, cl, t_we;
      int win;
      logic [2:0] t_a1, t_a2;
      logic [15:0] t_wd;
      ra = 1'($urandom);
      rb = 1'($urandom);
      if (!ra && !rb) rb = 1;
      cl = ($urandom_range(0, 4) == 0);
      scramble();
      req_a = ra;
      req_b = rb;
      if (ra && rb) win = 1 - m_last;
      else win = rb ? 1 : 0;
      t_we = win ? we_b : we_a;
      t_a1 = win ? addr1_b : addr1_a;
      t_a2 = win ? addr2_b : addr2_a;
      t_wd = win ? wdata_b : wdata_a;
      if (m_clear) begin
        step();
        total++;
        if ({rf_reset_enable, rf_set_enable, rf_get_enable} !== 3'b100) begin
          $display("FAIL rnd%0d_clear got %b want 100", it,
                   {rf_reset_enable, rf_set_enable, rf_get_enable});
        end else passed++;
        step();
        total++;
        if (clear_done !== 1'b1) begin
          $display("FAIL rnd%0d_clear_done got %b want 1", it, clear_done);
        end else passed++;
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_clear = 0;
      end
      step();
      total++;
      if ({rf_set_enable, rf_get_enable, rf_reset_enable} !==
          {t_we, ~t_we, 1'b0} || rf_num1 !== t_a1 || rf_num2 !== t_a2) begin
        $display("FAIL rnd%0d_issue got %b %0d %0d want %b %0d %0d", it,
                 {rf_set_enable, rf_get_enable, rf_reset_enable},
                 rf_num1, rf_num2, {t_we, ~t_we, 1'b0}, t_a1, t_a2);
      end else passed++;
      if (t_we) begin
        total++;
        if (rf_set_val !== t_wd) begin
          $display("FAIL rnd%0d_wdata got %h want %h", it, rf_set_val, t_wd);
        end else passed++;
      end
      scramble();
      clear_req = cl;
      step();
      clear_req = 0;
      step();
      step();
      if (t_we) begin
        m_mem[t_a1] = t_wd;
      end else begin
        m_rd1[win] = m_mem[t_a1];
        m_rd2[win] = m_mem[t_a2];
      end
      total++;
      if ({ack_a, ack_b} !== {win == 0, win == 1}) begin
        $display("FAIL rnd%0d_ack got %b want %b", it, {ack_a, ack_b},
                 {win == 0, win == 1});
      end else passed++;
      total++;
      if ({rdata1_a, rdata2_a, rdata1_b, rdata2_b} !==
          {m_rd1[0], m_rd2[0], m_rd1[1], m_rd2[1]}) begin
        $display("FAIL rnd%0d_rdata got %h want %h", it,
                 {rdata1_a, rdata2_a, rdata1_b, rdata2_b},
                 {m_rd1[0], m_rd2[0], m_rd1[1], m_rd2[1]});
      end else passed++;
      m_last = win;
      if (cl) m_clear = 1;
      req_a = 0;
      req_b = 0;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_async_reset();
    test_clear();
    step();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
